// File: rtl/rosc_sample_ctrl.sv
// Ring-oscillator bank controller: enable, warm-up, synchronized XOR sampling, word packing, valid/ack delivery.
// Optional von Neumann debiasing of the raw bit stream when ROSC_VN_DEBIAS_EN is defined.
module rosc_sample_ctrl #(
    parameter int unsigned NUM_ROSC      = 8,
    parameter int unsigned WARMUP_CYCLES = 256,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [15:0]           sample_div,
    input  logic [NUM_ROSC-1:0]   rosc_in,
    output logic [NUM_ROSC-1:0]   rosc_en,
    output logic                  busy,
    output logic                  entropy_valid,
    output logic [DATA_WIDTH-1:0] entropy_data,
    input  logic                  entropy_ack
);

    localparam int unsigned WCW = $clog2(WARMUP_CYCLES + 1);
    localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);
    localparam int unsigned TCW = 16;

    typedef enum logic [1:0] {IDLE, WARMUP, SAMPLE, FULL} state_t;

    state_t                state;
    logic [NUM_ROSC-1:0]   sync1;
    logic [NUM_ROSC-1:0]   sync2;
    logic [WCW-1:0]        warm_cnt;
    logic [TCW-1:0]        tick_cnt;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  raw_bit;
    logic                  tick;
    logic                  accept;
    logic                  accept_bit;
`ifdef ROSC_VN_DEBIAS_EN
    logic                  pair_phase;
    logic                  pair_b0;
`endif

    // Raw bit, tick strobe and accepted-bit selection.
    always_comb begin
        raw_bit    = ^sync2;
        tick       = (tick_cnt >= sample_div);
`ifdef ROSC_VN_DEBIAS_EN
        accept     = tick && pair_phase && (pair_b0 != raw_bit);
        accept_bit = pair_b0;
`else
        accept     = tick;
        accept_bit = raw_bit;
`endif
    end

    // Synchronizers run regardless of state; the FSM owns everything else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1         <= '0;
            sync2         <= '0;
            state         <= IDLE;
            rosc_en       <= '0;
            busy          <= 1'b0;
            entropy_valid <= 1'b0;
            entropy_data  <= '0;
            warm_cnt      <= '0;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
`ifdef ROSC_VN_DEBIAS_EN
            pair_phase    <= 1'b0;
            pair_b0       <= 1'b0;
`endif
        end else begin
            sync1 <= rosc_in;
            sync2 <= sync1;
            if (!enable) begin
                state         <= IDLE;
                rosc_en       <= '0;
                busy          <= 1'b0;
                entropy_valid <= 1'b0;
                entropy_data  <= '0;
                warm_cnt      <= '0;
                tick_cnt      <= '0;
                bit_cnt       <= '0;
                shreg         <= '0;
`ifdef ROSC_VN_DEBIAS_EN
                pair_phase    <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        state    <= WARMUP;
                        rosc_en  <= '1;
                        busy     <= 1'b1;
                        warm_cnt <= '0;
                    end
                    WARMUP: begin
                        if (warm_cnt == WCW'(WARMUP_CYCLES - 1)) begin
                            state    <= SAMPLE;
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
`ifdef ROSC_VN_DEBIAS_EN
                            pair_phase <= 1'b0;
`endif
                        end else begin
                            warm_cnt <= warm_cnt + WCW'(1);
                        end
                    end
                    SAMPLE: begin
                        // A full shift register is published one edge after its last bit lands.
                        if (bit_cnt == BCW'(DATA_WIDTH)) begin
                            entropy_data  <= shreg;
                            entropy_valid <= 1'b1;
                            state         <= FULL;
                        end else if (tick) begin
                            tick_cnt <= '0;
`ifdef ROSC_VN_DEBIAS_EN
                            pair_phase <= ~pair_phase;
                            if (!pair_phase) pair_b0 <= raw_bit;
`endif
                            if (accept) begin
                                shreg   <= {shreg[DATA_WIDTH-2:0], accept_bit};
                                bit_cnt <= bit_cnt + BCW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TCW'(1);
                        end
                    end
                    FULL: begin
                        if (entropy_ack && entropy_valid) begin
                            entropy_valid <= 1'b0;
                            entropy_data  <= '0;
                            bit_cnt       <= '0;
                            tick_cnt      <= '0;
                            state         <= SAMPLE;
`ifdef ROSC_VN_DEBIAS_EN
                            pair_phase    <= 1'b0;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rosc_sample_ctrl.sv
// Directed self-checking bench for rosc_sample_ctrl (WARMUP_CYCLES=4, DATA_WIDTH=32).
module tb_rosc_sample_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] sample_div;
    logic [7:0]  rosc_in;
    logic [7:0]  rosc_en;
    logic        busy;
    logic        entropy_valid;
    logic [31:0] entropy_data;
    logic        entropy_ack;

    int errors = 0;
    int checks = 0;

    rosc_sample_ctrl #(.NUM_ROSC(8), .WARMUP_CYCLES(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sample_div(sample_div),
        .rosc_in(rosc_in), .rosc_en(rosc_en), .busy(busy),
        .entropy_valid(entropy_valid), .entropy_data(entropy_data),
        .entropy_ack(entropy_ack)
    );

    always #5 clk = ~clk;

    task automatic go_edge();
        @(posedge clk);
        #1;
    endtask

    // Value to drive before edge c so that tick j (counted from the first tick) sees bit (j even).
    function automatic logic [7:0] tv(input int c, input int sd);
        int q;
        if (c < 2) return 8'h00;
        q = (c - 2) / (sd + 1);
        return (q % 2 == 1) ? 8'h01 : 8'h00;
    endfunction

    task automatic stop_run();
        enable = 1'b0;
        entropy_ack = 1'b0;
        go_edge();
        go_edge();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; sample_div = 16'd0; rosc_in = 8'h00; entropy_ack = 1'b0;
        #3;
        if ({rosc_en, busy, entropy_valid, entropy_data} !== 42'd0) begin
            $display("FAIL reset_outputs: got en=%h busy=%b v=%b d=%h required all zero", rosc_en, busy, entropy_valid, entropy_data);
            errors++;
        end
        checks++;
        go_edge();
        #2 reset_n = 1'b1;
        go_edge();
        if (busy !== 1'b0 || rosc_en !== 8'h00) begin
            $display("FAIL idle_after_reset: got busy=%b en=%h required 0/00", busy, rosc_en);
            errors++;
        end
        checks++;
    endtask

`ifndef ROSC_VN_DEBIAS_EN
    task automatic test_const_ones();
        int bad_busy = 0;
        rosc_in = 8'h01; sample_div = 16'd0;
        go_edge(); go_edge();
        enable = 1'b1;
        for (int c = 0; c <= 37; c++) begin
            go_edge();
            if (busy !== 1'b1) bad_busy++;
            if (c == 0) begin
                if (rosc_en !== 8'hFF) begin
                    $display("FAIL ones_rosc_en: got %h required ff", rosc_en);
                    errors++;
                end
                checks++;
            end
            if (entropy_valid !== (c >= 37)) begin
                $display("FAIL ones_valid_timing: cycle %0d got %b required %b", c, entropy_valid, (c >= 37));
                errors++;
            end
            checks++;
        end
        if (entropy_data !== 32'hFFFFFFFF) begin
            $display("FAIL ones_data: got %h required ffffffff", entropy_data);
            errors++;
        end
        checks++;
        if (bad_busy != 0) begin
            $display("FAIL ones_busy: got %0d low cycles required 0", bad_busy);
            errors++;
        end
        checks++;
        stop_run();
    endtask

    task automatic test_const_zero_ack();
        rosc_in = 8'h03; sample_div = 16'd0;
        go_edge(); go_edge();
        enable = 1'b1;
        for (int c = 0; c <= 37; c++) go_edge();
        if (entropy_valid !== 1'b1 || entropy_data !== 32'h0) begin
            $display("FAIL zero_word: got v=%b d=%h required 1/00000000", entropy_valid, entropy_data);
            errors++;
        end
        checks++;
        entropy_ack = 1'b1;
        go_edge();
        entropy_ack = 1'b0;
        if (entropy_valid !== 1'b0 || entropy_data !== 32'h0) begin
            $display("FAIL ack_clear: got v=%b d=%h required 0/00000000", entropy_valid, entropy_data);
            errors++;
        end
        checks++;
        for (int k = 1; k <= 33; k++) begin
            go_edge();
            if (entropy_valid !== (k == 33)) begin
                $display("FAIL second_word_timing: %0d after ack got %b required %b", k, entropy_valid, (k == 33));
                errors++;
            end
            checks++;
        end
        stop_run();
    endtask

    task automatic test_toggle(input int sd);
        int lat;
        lat = 5 + 32 * (sd + 1);
        sample_div = 16'(sd);
        rosc_in = 8'h00;
        go_edge(); go_edge();
        enable = 1'b1;
        for (int c = 0; c <= lat; c++) begin
            rosc_in = tv(c, sd);
            go_edge();
            if (c >= lat - 2 && entropy_valid !== (c >= lat)) begin
                $display("FAIL toggle_valid_sd%0d: cycle %0d got %b required %b", sd, c, entropy_valid, (c >= lat));
                errors++;
            end
            if (c >= lat - 2) checks++;
        end
        if (entropy_data !== 32'hAAAAAAAA) begin
            $display("FAIL toggle_data_sd%0d: got %h required aaaaaaaa", sd, entropy_data);
            errors++;
        end
        checks++;
        stop_run();
    endtask

    task automatic test_enable_drop();
        rosc_in = 8'h00; sample_div = 16'd0;
        go_edge(); go_edge();
        enable = 1'b1;
        for (int c = 0; c < 20; c++) go_edge();
        enable = 1'b0;
        go_edge();
        if (rosc_en !== 8'h00 || busy !== 1'b0 || entropy_valid !== 1'b0) begin
            $display("FAIL drop_idle: got en=%h busy=%b v=%b required 00/0/0", rosc_en, busy, entropy_valid);
            errors++;
        end
        checks++;
        rosc_in = 8'h01;
        go_edge(); go_edge();
        enable = 1'b1;
        for (int c = 0; c <= 37; c++) begin
            go_edge();
            if (c >= 35 && entropy_valid !== (c >= 37)) begin
                $display("FAIL reenable_timing: cycle %0d got %b required %b", c, entropy_valid, (c >= 37));
                errors++;
            end
            if (c >= 35) checks++;
        end
        if (entropy_data !== 32'hFFFFFFFF) begin
            $display("FAIL reenable_data: got %h required ffffffff", entropy_data);
            errors++;
        end
        checks++;
        stop_run();
    endtask

    task automatic test_hold_and_stray_ack();
        int unstable = 0;
        rosc_in = 8'h01; sample_div = 16'd0;
        go_edge(); go_edge();
        enable = 1'b1;
        for (int c = 0; c <= 37; c++) go_edge();
        rosc_in = 8'h00;
        for (int k = 0; k < 100; k++) begin
            go_edge();
            if (entropy_valid !== 1'b1 || entropy_data !== 32'hFFFFFFFF) unstable++;
        end
        if (unstable != 0) begin
            $display("FAIL hold_stable: got %0d unstable cycles required 0", unstable);
            errors++;
        end
        checks++;
        entropy_ack = 1'b1;
        go_edge();
        entropy_ack = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            entropy_ack = (k == 10);
            go_edge();
            if (k == 10 && entropy_valid !== 1'b0) begin
                $display("FAIL stray_ack: got v=%b required 0", entropy_valid);
                errors++;
            end
            if (k == 10) checks++;
        end
        entropy_ack = 1'b0;
        if (entropy_valid !== 1'b1 || entropy_data !== 32'h0) begin
            $display("FAIL post_hold_word: got v=%b d=%h required 1/00000000", entropy_valid, entropy_data);
            errors++;
        end
        checks++;
        stop_run();
    endtask

    task automatic test_async_reset();
        rosc_in = 8'h01; sample_div = 16'd0;
        go_edge(); go_edge();
        enable = 1'b1;
        for (int c = 0; c < 10; c++) go_edge();
        #2 reset_n = 1'b0;
        #1;
        if ({rosc_en, busy, entropy_valid, entropy_data} !== 42'd0) begin
            $display("FAIL async_reset: got en=%h busy=%b v=%b d=%h required all zero", rosc_en, busy, entropy_valid, entropy_data);
            errors++;
        end
        checks++;
        go_edge();
        go_edge();
        #2 reset_n = 1'b1;
        for (int c = 0; c <= 37; c++) go_edge();
        if (entropy_valid !== 1'b1 || entropy_data !== 32'hFFFFFFFF) begin
            $display("FAIL after_reset_word: got v=%b d=%h required 1/ffffffff", entropy_valid, entropy_data);
            errors++;
        end
        checks++;
        stop_run();
    endtask
`else
    task automatic test_debias_toggle();
        sample_div = 16'd0; rosc_in = 8'h00;
        go_edge(); go_edge();
        enable = 1'b1;
        for (int c = 0; c <= 69; c++) begin
            rosc_in = tv(c, 0);
            go_edge();
            if (c >= 67 && entropy_valid !== (c >= 69)) begin
                $display("FAIL vn_valid: cycle %0d got %b required %b", c, entropy_valid, (c >= 69));
                errors++;
            end
            if (c >= 67) checks++;
        end
        if (entropy_data !== 32'hFFFFFFFF) begin
            $display("FAIL vn_data: got %h required ffffffff", entropy_data);
            errors++;
        end
        checks++;
        stop_run();
    endtask

    task automatic test_debias_const();
        int seen = 0;
        sample_div = 16'd0; rosc_in = 8'h01;
        go_edge(); go_edge();
        enable = 1'b1;
        for (int c = 0; c < 200; c++) begin
            go_edge();
            if (entropy_valid !== 1'b0) seen++;
        end
        if (seen != 0) begin
            $display("FAIL vn_const: got %0d valid cycles required 0", seen);
            errors++;
        end
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL vn_busy: got %b required 1", busy);
            errors++;
        end
        checks++;
        stop_run();
    endtask
`endif

    initial begin
        test_reset();
`ifndef ROSC_VN_DEBIAS_EN
        test_const_ones();
        test_const_zero_ack();
        test_toggle(0);
        test_toggle(3);
        test_enable_drop();
        test_hold_and_stray_ack();
        test_async_reset();
`else
        test_debias_toggle();
        test_debias_const();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
